// File: rtl/fft4_pkg.sv
// fft4_pkg: shared widths and complex sample/frame types for the fft4 datapath.
package fft4_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int N_POINTS = 4;
    typedef struct packed {
        logic signed [DEF_DATA_WIDTH-1:0] re;
        logic signed [DEF_DATA_WIDTH-1:0] im;
    } cplx_t;
    typedef cplx_t [N_POINTS-1:0] frame_t;
endpackage

// File: rtl/fft4_frame_bank.sv
// fft4_frame_bank: 4-entry complex register file, sync clear, one write port, all entries readable.
module fft4_frame_bank import fft4_pkg::*; #(
    parameter int DW = DEF_DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 we,
    input  logic [1:0]           addr,
    input  logic signed [DW-1:0] wr_real,
    input  logic signed [DW-1:0] wr_imag,
    output logic signed [DW-1:0] rd_real [N_POINTS],
    output logic signed [DW-1:0] rd_imag [N_POINTS]
);
    logic signed [DW-1:0] re_q [N_POINTS];
    logic signed [DW-1:0] re_d [N_POINTS];
    logic signed [DW-1:0] im_q [N_POINTS];
    logic signed [DW-1:0] im_d [N_POINTS];

    always_comb begin
        for (int k = 0; k < N_POINTS; k++) begin
            re_d[k] = clr ? '0 : (we && addr == 2'(k)) ? wr_real : re_q[k];
            im_d[k] = clr ? '0 : (we && addr == 2'(k)) ? wr_imag : im_q[k];
        end
    end

    always_ff @(posedge clk) begin
        re_q <= re_d;
        im_q <= im_d;
    end

    assign rd_real = re_q;
    assign rd_imag = im_q;
endmodule

// File: rtl/fft4_frame_loader.sv
// fft4_frame_loader: serial complex samples -> 4-sample parallel frames via a ping-pong bank pair.
module fft4_frame_loader import fft4_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_real,
    input  logic signed [DATA_WIDTH-1:0] in_imag,
    input  logic                         in_last,
    output logic signed [DATA_WIDTH-1:0] out0_real,
    output logic signed [DATA_WIDTH-1:0] out1_real,
    output logic signed [DATA_WIDTH-1:0] out2_real,
    output logic signed [DATA_WIDTH-1:0] out3_real,
    output logic signed [DATA_WIDTH-1:0] out0_imag,
    output logic signed [DATA_WIDTH-1:0] out1_imag,
    output logic signed [DATA_WIDTH-1:0] out2_imag,
    output logic signed [DATA_WIDTH-1:0] out3_imag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         frame_err,
    output logic [CNT_WIDTH-1:0]         frame_cnt,
    output logic [CNT_WIDTH-1:0]         err_cnt
);
    logic [1:0]           full_q, full_d;
    logic                 wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0]           wr_cnt_q, wr_cnt_d;
    logic                 frame_err_q, frame_err_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
    logic                 acc, good, drop, hand, clr;
    logic signed [DATA_WIDTH-1:0] b0_re [N_POINTS];
    logic signed [DATA_WIDTH-1:0] b0_im [N_POINTS];
    logic signed [DATA_WIDTH-1:0] b1_re [N_POINTS];
    logic signed [DATA_WIDTH-1:0] b1_im [N_POINTS];

    assign in_ready  = rst_n & en & ~flush & ~full_q[wr_bank_q];
    assign out_valid = rst_n & full_q[rd_bank_q];
    assign acc  = in_valid & in_ready;
    // A frame closes on slot 3 with in_last; any disagreement between the two drops it.
    assign good = acc & (wr_cnt_q == 2'd3) & in_last;
    assign drop = acc & ((wr_cnt_q == 2'd3) != in_last);
    assign hand = out_valid & out_ready & en & ~flush;
    assign clr  = ~rst_n | flush;

    always_comb begin
        full_d = full_q;
        if (good)
            full_d[wr_bank_q] = 1'b1;
        if (hand)
            full_d[rd_bank_q] = 1'b0;
        full_d      = flush ? 2'b00 : full_d;
        wr_cnt_d    = flush ? 2'd0 : !acc ? wr_cnt_q : (wr_cnt_q == 2'd3 || in_last) ? 2'd0 : wr_cnt_q + 2'd1;
        wr_bank_d   = flush ? 1'b0 : wr_bank_q ^ good;
        rd_bank_d   = flush ? 1'b0 : rd_bank_q ^ hand;
        frame_err_d = flush ? 1'b0 : en ? drop : frame_err_q;
        frame_cnt_d = hand ? frame_cnt_q + CNT_WIDTH'(1) : frame_cnt_q;
        err_cnt_d   = (drop && !(&err_cnt_q)) ? err_cnt_q + CNT_WIDTH'(1) : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    fft4_frame_bank #(.DW(DATA_WIDTH)) u_bank0 (
        .clk(clk), .clr(clr), .we(acc & ~wr_bank_q), .addr(wr_cnt_q),
        .wr_real(in_real), .wr_imag(in_imag), .rd_real(b0_re), .rd_imag(b0_im)
    );

    fft4_frame_bank #(.DW(DATA_WIDTH)) u_bank1 (
        .clk(clk), .clr(clr), .we(acc & wr_bank_q), .addr(wr_cnt_q),
        .wr_real(in_real), .wr_imag(in_imag), .rd_real(b1_re), .rd_imag(b1_im)
    );

    assign out0_real = rd_bank_q ? b1_re[0] : b0_re[0];
    assign out1_real = rd_bank_q ? b1_re[1] : b0_re[1];
    assign out2_real = rd_bank_q ? b1_re[2] : b0_re[2];
    assign out3_real = rd_bank_q ? b1_re[3] : b0_re[3];
    assign out0_imag = rd_bank_q ? b1_im[0] : b0_im[0];
    assign out1_imag = rd_bank_q ? b1_im[1] : b0_im[1];
    assign out2_imag = rd_bank_q ? b1_im[2] : b0_im[2];
    assign out3_imag = rd_bank_q ? b1_im[3] : b0_im[3];
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_fft4_frame_loader.sv
// tb_fft4_frame_loader: directed frames with a scoreboard queue checked by an output monitor.
module tb_fft4_frame_loader;
    import fft4_pkg::*;

    logic clk = 1'b0;
    logic rst_n, en, flush, in_valid, in_ready, in_last, out_valid, out_ready, frame_err;
    logic signed [7:0] in_real, in_imag;
    logic signed [7:0] out0_real, out1_real, out2_real, out3_real;
    logic signed [7:0] out0_imag, out1_imag, out2_imag, out3_imag;
    logic [15:0] frame_cnt, err_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int stall_cnt = 0;
    frame_t exp_q[$];
    frame_t got_f, exp_f;
    frame_t f1, f2, f3, f4, f5, f6, f7, fa, fb, fc;

    always #5 clk = ~clk;

    fft4_frame_loader dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
        .out0_real(out0_real), .out1_real(out1_real), .out2_real(out2_real), .out3_real(out3_real),
        .out0_imag(out0_imag), .out1_imag(out1_imag), .out2_imag(out2_imag), .out3_imag(out3_imag),
        .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic frame_t mkf(input int r0, i0, r1, i1, r2, i2, r3, i3);
        frame_t f;
        f[0].re = 8'(r0); f[0].im = 8'(i0);
        f[1].re = 8'(r1); f[1].im = 8'(i1);
        f[2].re = 8'(r2); f[2].im = 8'(i2);
        f[3].re = 8'(r3); f[3].im = 8'(i3);
        return f;
    endfunction

    // Monitor: a frame is consumed at the next edge whenever it is valid and accepted.
    always @(negedge clk) begin
        if (out_valid && out_ready && en && !flush) begin
            got_f[0].re = out0_real; got_f[0].im = out0_imag;
            got_f[1].re = out1_real; got_f[1].im = out1_imag;
            got_f[2].re = out2_real; got_f[2].im = out2_imag;
            got_f[3].re = out3_real; got_f[3].im = out3_imag;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL frame_unexpected: got %h expected none at %0t", got_f, $time);
            end else begin
                exp_f = exp_q.pop_front();
                if (got_f !== exp_f) begin
                    n_fail++;
                    $display("FAIL frame_data: got %h expected %h at %0t", got_f, exp_f, $time);
                end
            end
        end
    end

    task automatic send_sample(input int r, input int i, input bit last);
        int t = 0;
        in_real = 8'(r);
        in_imag = 8'(i);
        in_last = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 at %0t", $time);
        end
        if (t > 0)
            stall_cnt++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_frame(input frame_t f);
        exp_q.push_back(f);
        for (int k = 0; k < 4; k++)
            send_sample(f[k].re, f[k].im, k == 3);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue", exp_q.size(), 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        f1 = mkf(1, 0, 2, 0, -1, 0, 3, 0);
        fa = mkf(10, -10, 11, -11, 12, -12, 13, -13);
        fb = mkf(-128, 127, 127, -128, 0, 1, -1, 0);
        fc = mkf(20, 21, 22, 23, 24, 25, 26, 27);
        f2 = mkf(31, 1, 32, 2, 33, 3, 34, 4);
        f3 = mkf(-41, 5, -42, 6, -43, 7, -44, 8);
        f4 = mkf(5, -4, 6, 7, -8, 1, 0, 2);
        f5 = mkf(-7, -6, -5, -4, -3, -2, -1, 99);
        f6 = mkf(50, 51, 52, 53, 54, 55, 56, 57);
        f7 = mkf(-60, 61, -62, 63, -64, 65, -66, 67);
        rst_n = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_real = '0; in_imag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_err_cnt", err_cnt, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_out0_real", out0_real, 0);
        chk("idle_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // basic frame, one-cycle latency
        send_frame(f1);
        @(negedge clk);
        chk("basic_latency_valid", out_valid, 1);
        @(posedge clk);
        @(negedge clk);
        chk("basic_frame_cnt", frame_cnt, 1);
        chk("basic_valid_cleared", out_valid, 0);
        @(posedge clk); #1;

        // back-to-back, no stalls expected
        stall_cnt = 0;
        send_frame(fa);
        send_frame(fb);
        send_frame(fc);
        chk("b2b_no_stall", stall_cnt, 0);
        wait_drain();
        chk("b2b_frame_cnt", frame_cnt, 4);
        @(posedge clk); #1;

        // backpressure: two banks fill, third frame stalls
        out_ready = 1'b0;
        fork
            begin
                send_frame(f2);
                send_frame(f3);
                send_frame(f4);
            end
            begin
                repeat (10) @(negedge clk);
                chk("bp_hold_out1_a", out1_real, f2[1].re);
                repeat (2) @(negedge clk);
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_hold_out1_b", out1_real, f2[1].re);
                chk("bp_hold_out3_imag", out3_imag, f2[3].im);
                chk("bp_frame_cnt_hold", frame_cnt, 4);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_frame_cnt", frame_cnt, 7);
        @(posedge clk); #1;

        // misalignment: in_last on the second sample
        send_sample(9, 9, 0);
        send_sample(8, 8, 1);
        @(negedge clk);
        chk("misalign_err_pulse", frame_err, 1);
        chk("misalign_no_valid", out_valid, 0);
        @(negedge clk);
        chk("misalign_err_one_cycle", frame_err, 0);
        chk("misalign_err_cnt", err_cnt, 1);
        @(posedge clk); #1;
        send_frame(f4);
        wait_drain();
        chk("misalign_frame_cnt", frame_cnt, 8);
        @(posedge clk); #1;

        // missing last: four samples without in_last
        for (int k = 0; k < 4; k++)
            send_sample(70 + k, k, 0);
        @(negedge clk);
        chk("nolast_err_pulse", frame_err, 1);
        chk("nolast_no_valid", out_valid, 0);
        @(negedge clk);
        chk("nolast_err_cnt", err_cnt, 2);
        @(posedge clk); #1;
        send_frame(f5);
        wait_drain();
        chk("nolast_frame_cnt", frame_cnt, 9);
        @(posedge clk); #1;

        // flush mid-frame
        send_sample(88, 88, 0);
        send_sample(89, 89, 0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        send_frame(f6);
        @(negedge clk);
        chk("flush_no_err", frame_err, 0);
        wait_drain();
        chk("flush_frame_cnt", frame_cnt, 10);
        chk("flush_err_cnt", err_cnt, 2);
        @(posedge clk); #1;

        // reset mid-frame
        send_sample(90, 90, 0);
        send_sample(91, 91, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready", in_ready, 0);
        chk("rst_mid_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_frame_cnt", frame_cnt, 0);
        chk("rst_mid_err_cnt", err_cnt, 0);
        chk("rst_mid_out0_real", out0_real, 0);
        chk("rst_mid_out3_imag", out3_imag, 0);
        @(posedge clk); #1;
        send_frame(f7);
        @(negedge clk);
        chk("rst_mid_no_err", frame_err, 0);
        wait_drain();
        chk("rst_mid_frame_cnt_after", frame_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fft4_frame_loader.md
Name: fft4_frame_loader

Overview:
- Upstream stage of fft4: turns a serial complex sample stream (one sample per valid/ready beat) into 4-sample parallel frames that drive fft4 in0..in3 plus its en.
- Ping-pong double buffer, so one frame can fill while the previous frame waits for the consumer.
- Frame boundaries are checked with in_last. Misaligned frames are dropped and flagged.

Parameters:
- DATA_WIDTH, 8, signed width of each real/imag component, in and out.
- CNT_WIDTH, 16, width of the frame and error counters.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  global enable; when 0 all state freezes.
- flush  in  1  synchronous clear of both banks and the write position.
- in_valid  in  1  input sample valid.
- in_ready  out  1  loader can accept a sample.
- in_real  in  DATA_WIDTH  signed sample real part.
- in_imag  in  DATA_WIDTH  signed sample imag part.
- in_last  in  1  marks the 4th sample of a frame.
- out0_real .. out3_real  out  DATA_WIDTH each  frame samples 0..3 real part (to fft4 inK_real).
- out0_imag .. out3_imag  out  DATA_WIDTH each  frame samples 0..3 imag part.
- out_valid  out  1  complete frame present (drives fft4 en).
- out_ready  in  1  consumer accepts the frame (tie 1 for fft4).
- frame_err  out  1  one-cycle pulse when a misaligned frame is dropped.
- frame_cnt  out  CNT_WIDTH  frames handed out, wraps.
- err_cnt  out  CNT_WIDTH  dropped frames, saturates at all-ones.

Behaviour:
- State:
  - bank0, bank1: 4 complex entries each.
  - bank_full[1:0]
  - wr_bank, rd_bank: 1 bit each.
  - wr_cnt: 2 bits.
- Reset (rst_n=0 at a clk edge):
  - banks = 0, bank_full = 0, wr_bank = rd_bank = 0, wr_cnt = 0.
  - Counters = 0, frame_err = 0.
  - in_ready = 0 and out_valid = 0 while rst_n = 0.
  - Reset in mid-frame discards the partial frame; no frame_err.
- in_ready = rst_n & en & !flush & !bank_full[wr_bank], combinational.
- Accept when in_valid & in_ready: write the sample to bank[wr_bank] entry wr_cnt.
  - wr_cnt < 3 and !in_last: wr_cnt++.
  - wr_cnt == 3 and in_last: set bank_full[wr_bank], toggle wr_bank, wr_cnt = 0.
  - wr_cnt == 3 and !in_last: drop the frame, wr_cnt = 0, frame_err pulse, err_cnt++.
  - wr_cnt < 3 and in_last: drop the frame, wr_cnt = 0, frame_err pulse, err_cnt++.
  - A dropped frame never sets bank_full. Bank contents may be stale but are never presented.
- Output: out_valid = rst_n & bank_full[rd_bank]. outK_* are driven from bank[rd_bank] entry K (mux, no extra register).
- Hand-off when out_valid & out_ready & en & !flush: clear bank_full[rd_bank], toggle rd_bank, frame_cnt++.
- Latency: 4th sample accepted at edge N → out_valid=1 after edge N, visible in cycle N+1.
- Throughput: with out_ready=1, sustained 1 sample/clk with no bubbles.
- out_valid high with out_ready low: outputs stay stable. Filling of the other bank continues. When both banks are full, in_ready=0.
- Same edge fills one bank and drains the other: both happen. This is the normal overlap case.
- The write side never targets a full bank, guaranteed by in_ready.
- en=0: no accept, no hand-off, counters and pulses hold, outputs stable.
- flush=1 (and en irrelevant): bank_full = 0, wr_cnt = 0, wr_bank = rd_bank = 0. Counters are kept; no frame_err. flush wins over a simultaneous accept or hand-off.
- frame_err is registered: high exactly one cycle after the dropping edge.
- Widths: samples pass through unchanged, with no growth or rounding. fft4 performs the growth to DATA_WIDTH+2.

Decomposition:
- fft4_pkg holds:
  - DATA_WIDTH default (8) and N_POINTS = 4.
  - Complex sample struct {signed real, signed imag}.
  - Frame array type.
- Sub-module fft4_frame_bank: 4-entry complex register file with synchronous clear, write enable, 2-bit address and 4 parallel read outputs. Instantiated twice.
- Top level holds the control, the muxes and the counters.

Test Plan:
- Basic frame: reset, then stream (1,0),(2,0),(-1,0),(3,0) with in_last on the 4th, out_ready=1 → one cycle later out_valid=1 with out0..3_real = 1,2,-1,3 and imag all 0; frame_cnt=1.
- Back-to-back: 3 frames with no gaps, out_ready=1 → in_ready stays 1 throughout; out_valid pulses every 4th cycle; frame_cnt=3; data matches per frame.
- Backpressure: out_ready=0, send 3 frames → frame 1 held on the outputs; in_ready drops after frame 2's last sample; frame 3 stalls. Raise out_ready → frames 1, 2, 3 emerge in order.
- Misalignment: in_last on the 2nd sample → frame_err pulse one cycle later, err_cnt=1, no out_valid. The next good frame (5,-4),(6,7),(-8,1),(0,2) is output intact.
- Missing last: 4 samples without in_last → frame dropped, err_cnt increments, wr_cnt back to 0.
- Flush/reset mid-frame: after 2 samples assert flush, then send a full frame → only the new frame appears. Repeat with rst_n=0 → all outputs 0, counters 0.
